// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Groups the cache-side request/response signals and the shared bus-side
// signals of mem_port_arbiter.
//   inst_*            instruction-cache miss path (request pulse, ready pulse, read data)
//   data_*            data-cache access path (request pulse with type/size/wdata, ready, rdata)
//   bus_*             shared memory port (call_begin pulse, command fields, completion, rdata)
//   timeout_err       one-cycle pulse alongside a watchdog-forced response
//   overrun           sticky flag for a request dropped because its side was busy
// Modports: slave = the arbiter, master = the caches/bus environment driving it.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wen;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic [31:0] data_rdata;

    logic        bus_call_begin;
    logic        bus_wen;
    logic [2:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_return_ready;
    logic [31:0] bus_rdata;

    logic        timeout_err;
    logic        overrun;

    modport slave (
        input  inst_req, inst_addr,
        output inst_ready, inst_rdata,
        input  data_req, data_wen, data_size, data_addr, data_wdata,
        output data_ready, data_rdata,
        output bus_call_begin, bus_wen, bus_size, bus_addr, bus_wdata,
        input  bus_return_ready, bus_rdata,
        output timeout_err, overrun
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_ready, inst_rdata,
        output data_req, data_wen, data_size, data_addr, data_wdata,
        input  data_ready, data_rdata,
        input  bus_call_begin, bus_wen, bus_size, bus_addr, bus_wdata,
        output bus_return_ready, bus_rdata,
        input  timeout_err, overrun
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory-bus port between the instruction-cache miss path and the
// data-cache access path. Request pulses are latched per side, ties are broken
// round-robin, one transaction is in flight at a time, and a watchdog forces an
// error response when the bus never completes.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   arb     mem_port_arbiter_if.slave: cache request/response, bus command/response,
//           timeout_err pulse and sticky overrun flag
// Parameters:
//   TIMEOUT  WAIT cycles before a forced error response (0 disables the watchdog)
//   TO_W     watchdog counter width, TIMEOUT < 2**TO_W
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input logic               clk,
    input logic               resetn,
    mem_port_arbiter_if.slave arb
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic OwnInst = 1'b0;
    localparam logic OwnData = 1'b1;

    // Compared one cycle early so the forced response registers on cycle TIMEOUT.
    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;   // current owner, doubles as last grant winner
    logic [TO_W-1:0] wd_q, wd_d;

    logic        inst_pend_q, inst_pend_d;
    logic [31:0] inst_addr_q, inst_addr_d;

    logic        data_pend_q, data_pend_d;
    logic        data_wen_q, data_wen_d;
    logic [2:0]  data_size_q, data_size_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;

    logic        bus_wen_q, bus_wen_d;
    logic [2:0]  bus_size_q, bus_size_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        inst_ready_q, inst_ready_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic        data_ready_q, data_ready_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        timeout_err_q, timeout_err_d;
    logic        overrun_q, overrun_d;

    logic inst_busy, data_busy;
    logic inst_cand, data_cand;
    logic grant_inst, grant_data;
    logic timeout_hit;

    // A side is busy while it has a stored request or owns the bus.
    assign inst_busy = inst_pend_q | ((state_q != StIdle) && (owner_q == OwnInst));
    assign data_busy = data_pend_q | ((state_q != StIdle) && (owner_q == OwnData));

    assign inst_cand  = inst_pend_q | arb.inst_req;
    assign data_cand  = data_pend_q | arb.data_req;
    // On a tie the side that did not win last time goes first.
    assign grant_data = data_cand & (~inst_cand | (owner_q == OwnInst));
    assign grant_inst = inst_cand & ~grant_data;

    assign timeout_hit = (TIMEOUT != 0) && (wd_q == ToLast);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        wd_d          = wd_q;
        inst_pend_d   = inst_pend_q;
        inst_addr_d   = inst_addr_q;
        data_pend_d   = data_pend_q;
        data_wen_d    = data_wen_q;
        data_size_d   = data_size_q;
        data_addr_d   = data_addr_q;
        data_wdata_d  = data_wdata_q;
        bus_wen_d     = bus_wen_q;
        bus_size_d    = bus_size_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        inst_ready_d  = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        data_ready_d  = 1'b0;
        data_rdata_d  = data_rdata_q;
        timeout_err_d = 1'b0;
        overrun_d     = overrun_q;

        // Request capture; a pulse from a busy side is dropped and flagged.
        if (arb.inst_req) begin
            if (inst_busy) begin
                overrun_d = 1'b1;
            end else begin
                inst_pend_d = 1'b1;
                inst_addr_d = arb.inst_addr;
            end
        end
        if (arb.data_req) begin
            if (data_busy) begin
                overrun_d = 1'b1;
            end else begin
                data_pend_d  = 1'b1;
                data_wen_d   = arb.data_wen;
                data_size_d  = arb.data_size;
                data_addr_d  = arb.data_addr;
                data_wdata_d = arb.data_wdata;
            end
        end

        unique case (state_q)
            StIdle: begin
                // A same-cycle pulse is granted straight from the live inputs.
                if (grant_data) begin
                    state_d     = StIssue;
                    owner_d     = OwnData;
                    data_pend_d = 1'b0;
                    bus_wen_d   = data_pend_q ? data_wen_q   : arb.data_wen;
                    bus_size_d  = data_pend_q ? data_size_q  : arb.data_size;
                    bus_addr_d  = data_pend_q ? data_addr_q  : arb.data_addr;
                    bus_wdata_d = data_pend_q ? data_wdata_q : arb.data_wdata;
                end else if (grant_inst) begin
                    state_d     = StIssue;
                    owner_d     = OwnInst;
                    inst_pend_d = 1'b0;
                    bus_wen_d   = 1'b0;
                    bus_size_d  = 3'b100;
                    bus_addr_d  = inst_pend_q ? inst_addr_q : arb.inst_addr;
                    bus_wdata_d = 32'h0;
                end
            end
            StIssue: begin
                state_d = StWait;
                wd_d    = '0;
            end
            StWait: begin
                wd_d = wd_q + 1'b1;
                if (arb.bus_return_ready || timeout_hit) begin
                    // A real completion wins over a watchdog expiry in the same cycle.
                    if (owner_q == OwnInst) begin
                        inst_ready_d = 1'b1;
                        inst_rdata_d = arb.bus_return_ready ? arb.bus_rdata : 32'h0;
                    end else begin
                        data_ready_d = 1'b1;
                        data_rdata_d = arb.bus_return_ready ? arb.bus_rdata : 32'h0;
                    end
                    timeout_err_d = ~arb.bus_return_ready;
                    state_d       = StIdle;
                    bus_wen_d     = 1'b0;
                    bus_size_d    = 3'b000;
                    bus_addr_d    = 32'h0;
                    bus_wdata_d   = 32'h0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            owner_q       <= OwnInst;
            wd_q          <= '0;
            inst_pend_q   <= 1'b0;
            inst_addr_q   <= 32'h0;
            data_pend_q   <= 1'b0;
            data_wen_q    <= 1'b0;
            data_size_q   <= 3'b000;
            data_addr_q   <= 32'h0;
            data_wdata_q  <= 32'h0;
            bus_wen_q     <= 1'b0;
            bus_size_q    <= 3'b000;
            bus_addr_q    <= 32'h0;
            bus_wdata_q   <= 32'h0;
            inst_ready_q  <= 1'b0;
            inst_rdata_q  <= 32'h0;
            data_ready_q  <= 1'b0;
            data_rdata_q  <= 32'h0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wd_q          <= wd_d;
            inst_pend_q   <= inst_pend_d;
            inst_addr_q   <= inst_addr_d;
            data_pend_q   <= data_pend_d;
            data_wen_q    <= data_wen_d;
            data_size_q   <= data_size_d;
            data_addr_q   <= data_addr_d;
            data_wdata_q  <= data_wdata_d;
            bus_wen_q     <= bus_wen_d;
            bus_size_q    <= bus_size_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            inst_ready_q  <= inst_ready_d;
            inst_rdata_q  <= inst_rdata_d;
            data_ready_q  <= data_ready_d;
            data_rdata_q  <= data_rdata_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign arb.bus_call_begin = (state_q == StIssue);
    assign arb.bus_wen        = bus_wen_q;
    assign arb.bus_size       = bus_size_q;
    assign arb.bus_addr       = bus_addr_q;
    assign arb.bus_wdata      = bus_wdata_q;
    assign arb.inst_ready     = inst_ready_q;
    assign arb.inst_rdata     = inst_rdata_q;
    assign arb.data_ready     = data_ready_q;
    assign arb.data_rdata     = data_rdata_q;
    assign arb.timeout_err    = timeout_err_q;
    assign arb.overrun        = overrun_q;

endmodule
